// File: rtl/alu_mul_seq_if.sv
// -----------------------------------------------------------------------------
// alu_mul_seq_if
// Bundles the control-unit handshake and the shared-ALU port of alu_mul_seq.
//   start, op_a, op_b      : request and operands from the control unit
//   busy, done, product, ovf : status and result back to the control unit
//   alu_a, alu_b, alu_s,
//   alu_m, alu_cn          : operands/function driven onto the shared ALU
//   alu_f, alu_cf          : combinational ALU result and carry flag
// master : the environment side (control unit + ALU)
// slave  : the sequencer itself
// -----------------------------------------------------------------------------
interface alu_mul_seq_if;
   logic        start;
   logic [15:0] op_a;
   logic [15:0] op_b;
   logic        busy;
   logic        done;
   logic [15:0] product;
   logic        ovf;
   logic [15:0] alu_a;
   logic [15:0] alu_b;
   logic [3:0]  alu_s;
   logic        alu_m;
   logic        alu_cn;
   logic [15:0] alu_f;
   logic        alu_cf;

   modport master (
      output start, op_a, op_b, alu_f, alu_cf,
      input  busy, done, product, ovf, alu_a, alu_b, alu_s, alu_m, alu_cn
   );

   modport slave (
      input  start, op_a, op_b, alu_f, alu_cf,
      output busy, done, product, ovf, alu_a, alu_b, alu_s, alu_m, alu_cn
   );
endinterface

// File: rtl/alu_mul_seq.sv
// -----------------------------------------------------------------------------
// alu_mul_seq
// Computes the low 16 bits of a 16x16 unsigned product on a shared 16-bit
// combinational ALU, one ALU operation per clock, using MSB-first
// double-and-add over the multiplier. A sticky flag records any carry-out,
// i.e. a true product wider than 16 bits.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : alu_mul_seq_if.slave (handshake, result, shared-ALU drive/return)
// -----------------------------------------------------------------------------
module alu_mul_seq (
   input  logic              clk,
   input  logic              rst_n,
   alu_mul_seq_if.slave      bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DBL  = 2'd1,
      ADD  = 2'd2,
      DONE = 2'd3
   } state_t;

   // ALU function codes
   localparam logic [3:0] ALU_S_PASS_A = 4'b1111;  // with M=1: F = A
   localparam logic [3:0] ALU_S_A_PL_A = 4'b1100;  // with M=0: F = A + A
   localparam logic [3:0] ALU_S_A_PL_B = 4'b1001;  // with M=0: F = A + B

   state_t      state, state_nxt;
   logic [15:0] acc;
   logic [15:0] mcand;
   logic [15:0] mplier;
   logic [3:0]  idx;
   logic        ovf_r;

   logic        load;
   logic        acc_we;
   logic        idx_dec;
   logic        busy_c;
   logic        done_c;
   logic [3:0]  alu_s_c;
   logic        alu_m_c;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and ALU drive
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      acc_we    = 1'b0;
      idx_dec   = 1'b0;
      busy_c    = 1'b0;
      done_c    = 1'b0;
      alu_s_c   = ALU_S_PASS_A;
      alu_m_c   = 1'b1;

      case (state)
         IDLE: begin
            if (bus.start) begin
               load      = 1'b1;
               state_nxt = DBL;
            end
         end

         DBL: begin
            busy_c  = 1'b1;
            acc_we  = 1'b1;
            alu_s_c = ALU_S_A_PL_A;
            alu_m_c = 1'b0;
            if (mplier[idx]) begin
               // idx is kept so the ADD step sees the same bit position
               state_nxt = ADD;
            end else if (idx == 4'd0) begin
               state_nxt = DONE;
            end else begin
               idx_dec   = 1'b1;
               state_nxt = DBL;
            end
         end

         ADD: begin
            busy_c  = 1'b1;
            acc_we  = 1'b1;
            alu_s_c = ALU_S_A_PL_B;
            alu_m_c = 1'b0;
            if (idx == 4'd0) begin
               state_nxt = DONE;
            end else begin
               idx_dec   = 1'b1;
               state_nxt = DBL;
            end
         end

         DONE: begin
            done_c = 1'b1;
            // A start here chains straight into the next product
            if (bus.start) begin
               load      = 1'b1;
               state_nxt = DBL;
            end else begin
               state_nxt = IDLE;
            end
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc    <= 16'd0;
         mcand  <= 16'd0;
         mplier <= 16'd0;
         idx    <= 4'd0;
         ovf_r  <= 1'b0;
      end else if (load) begin
         acc    <= 16'd0;
         mcand  <= bus.op_a;
         mplier <= bus.op_b;
         idx    <= 4'd15;
         ovf_r  <= 1'b0;
      end else begin
         if (acc_we) begin
            acc <= bus.alu_f;
            // Carry flag is active-low in arithmetic mode
            if (!bus.alu_cf) begin
               ovf_r <= 1'b1;
            end
         end
         if (idx_dec) begin
            idx <= idx - 4'd1;
         end
      end
   end

   assign bus.busy    = busy_c;
   assign bus.done    = done_c;
   assign bus.product = acc;
   assign bus.ovf     = ovf_r;
   assign bus.alu_a   = acc;
   assign bus.alu_b   = mcand;
   assign bus.alu_s   = alu_s_c;
   assign bus.alu_m   = alu_m_c;
   assign bus.alu_cn  = 1'b1;

endmodule

// File: tb/tb_alu_mul_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_mul_seq
// Directed bench for alu_mul_seq. Models the shared combinational ALU for the
// three function codes the sequencer uses and checks result, overflow,
// start-to-done latency and busy/ADD cycle counts against hand-computed values.
// -----------------------------------------------------------------------------
module tb_alu_mul_seq;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_fail;

   alu_mul_seq_if bus ();

   alu_mul_seq dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Shared ALU: active-high data, carry flag low when carry-out occurs
   logic [16:0] alu_sum;
   always_comb begin
      alu_sum    = 17'd0;
      bus.alu_f  = 16'd0;
      bus.alu_cf = 1'b1;
      if (bus.alu_m) begin
         if (bus.alu_s == 4'b1111) bus.alu_f = bus.alu_a;
      end else begin
         if (bus.alu_s == 4'b1100)
            alu_sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_a};
         else if (bus.alu_s == 4'b1001)
            alu_sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
         bus.alu_f  = alu_sum[15:0];
         bus.alu_cf = ~alu_sum[16];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Issue a one-cycle start and follow the sequence to done
   task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] exp_p, input logic exp_o,
                         input int exp_lat, input int exp_busy, input int exp_add);
      int lat, nb, na;
      lat = 0; nb = 0; na = 0;
      @(negedge clk);
      bus.start = 1'b1;
      bus.op_a  = a;
      bus.op_b  = b;
      for (int k = 1; k <= 100; k++) begin
         @(negedge clk);
         bus.start = 1'b0;
         lat = k;
         if (bus.busy) nb++;
         if (bus.busy && bus.alu_s == 4'b1001) na++;
         if (bus.done) break;
      end
      chk({tag, "_lat"},  lat, exp_lat);
      chk({tag, "_prod"}, {16'd0, bus.product}, {16'd0, exp_p});
      chk({tag, "_ovf"},  {31'd0, bus.ovf}, {31'd0, exp_o});
      chk({tag, "_busy"}, nb, exp_busy);
      chk({tag, "_add"},  na, exp_add);
      chk({tag, "_bsy_at_done"}, {31'd0, bus.busy}, 32'd0);
   endtask

   initial begin
      int lat, nb;
      n_cmp  = 0;
      n_fail = 0;
      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.op_a  = 16'd0;
      bus.op_b  = 16'd0;
      repeat (2) @(negedge clk);

      // Reset state
      chk("rst_busy",  {31'd0, bus.busy}, 32'd0);
      chk("rst_done",  {31'd0, bus.done}, 32'd0);
      chk("rst_prod",  {16'd0, bus.product}, 32'd0);
      chk("rst_ovf",   {31'd0, bus.ovf}, 32'd0);
      chk("rst_alu_s", {28'd0, bus.alu_s}, 32'hF);
      chk("rst_alu_m", {31'd0, bus.alu_m}, 32'd1);
      chk("rst_alu_cn",{31'd0, bus.alu_cn}, 32'd1);
      chk("rst_alu_b", {16'd0, bus.alu_b}, 32'd0);
      rst_n = 1'b1;

      run_op("m3x5",   16'd3,     16'd5,     16'h000F, 1'b0, 19, 18, 2);
      run_op("m100sq", 16'h0100,  16'h0100,  16'h0000, 1'b1, 18, 17, 1);
      run_op("mffffx1",16'hFFFF,  16'd1,     16'hFFFF, 1'b0, 18, 17, 1);

      // Result holds after done drops
      @(negedge clk);
      chk("hold_done", {31'd0, bus.done}, 32'd0);
      chk("hold_prod", {16'd0, bus.product}, 32'h0000FFFF);

      run_op("m1234x0",16'h1234,  16'd0,     16'h0000, 1'b0, 17, 16, 0);

      // Start held high: chained restart from DONE
      @(negedge clk);
      bus.start = 1'b1;
      bus.op_a  = 16'd2;
      bus.op_b  = 16'd3;
      lat = 0;
      for (int k = 1; k <= 100; k++) begin
         @(negedge clk);
         lat = k;
         if (bus.done) break;
      end
      chk("held_lat",  lat, 19);
      chk("held_prod", {16'd0, bus.product}, 32'd6);
      @(negedge clk);
      chk("held_restart_busy", {31'd0, bus.busy}, 32'd1);
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      // Start with different operands while busy must be ignored
      bus.start = 1'b1;
      bus.op_a  = 16'hFFFF;
      bus.op_b  = 16'hFFFF;
      @(negedge clk);
      bus.start = 1'b0;
      bus.op_a  = 16'd0;
      bus.op_b  = 16'd0;
      lat = 0;
      for (int k = 1; k <= 100; k++) begin
         lat = k;
         if (bus.done) break;
         @(negedge clk);
      end
      chk("ign_lat_bound", {31'd0, lat > 99}, 32'd0);
      chk("ign_prod", {16'd0, bus.product}, 32'd6);
      chk("ign_ovf",  {31'd0, bus.ovf}, 32'd0);
      repeat (2) @(negedge clk);

      // Async reset mid-sequence
      bus.start = 1'b1;
      bus.op_a  = 16'hFFFF;
      bus.op_b  = 16'hFFFF;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (10) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_busy",  {31'd0, bus.busy}, 32'd0);
      chk("arst_done",  {31'd0, bus.done}, 32'd0);
      chk("arst_prod",  {16'd0, bus.product}, 32'd0);
      chk("arst_ovf",   {31'd0, bus.ovf}, 32'd0);
      chk("arst_alu_a", {16'd0, bus.alu_a}, 32'd0);
      chk("arst_alu_b", {16'd0, bus.alu_b}, 32'd0);
      chk("arst_alu_s", {28'd0, bus.alu_s}, 32'hF);
      chk("arst_alu_m", {31'd0, bus.alu_m}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      nb = 0;
      repeat (5) begin
         @(negedge clk);
         if (bus.busy) nb++;
      end
      chk("arst_no_restart", nb, 0);

      run_op("m7x6",    16'd7,    16'd6,    16'd42,   1'b0, 19, 18, 2);
      run_op("mffffsq", 16'hFFFF, 16'hFFFF, 16'h0001, 1'b1, 33, 32, 16);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
